// File: rtl/brush_fb_writer.sv
// Brush framebuffer writer: commits a clamped brush square (or a full-screen
// clear) into framebuffer memory, one valid/ready write per pixel, row-major.
module brush_fb_writer #(
  parameter int       RESOLUTION_H = 640,
  parameter int       RESOLUTION_V = 480,
  parameter int       HPOS_WIDTH   = 10,
  parameter int       VPOS_WIDTH   = 9,
  parameter int       ADDR_WIDTH   = 19,
  parameter int       BRUSH_SIZE   = 20,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  paint_req,
  input  logic                  clear_req,
  input  logic [HPOS_WIDTH-1:0] cursor_xpos,
  input  logic [VPOS_WIDTH-1:0] cursor_ypos,
  input  logic [2:0]            color_in,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [2:0]            fb_wdata,
  input  logic                  fb_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [HPOS_WIDTH-1:0] X_MAX    = HPOS_WIDTH'(RESOLUTION_H - 1);
  localparam logic [VPOS_WIDTH-1:0] Y_MAX    = VPOS_WIDTH'(RESOLUTION_V - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(RESOLUTION_H);

  // Lower edge clamp: one extra sign bit so a centre closer than BRUSH_SIZE to 0 saturates instead of wrapping.
  function automatic logic [HPOS_WIDTH-1:0] clamp_x_lo(input logic [HPOS_WIDTH-1:0] p);
    logic signed [HPOS_WIDTH:0] d;
    d = $signed({1'b0, p}) - $signed((HPOS_WIDTH+1)'(BRUSH_SIZE));
    return (d < 0) ? '0 : d[HPOS_WIDTH-1:0];
  endfunction

  function automatic logic [HPOS_WIDTH-1:0] clamp_x_hi(input logic [HPOS_WIDTH-1:0] p);
    logic [HPOS_WIDTH:0] s;
    s = {1'b0, p} + (HPOS_WIDTH+1)'(BRUSH_SIZE);
    return (s > {1'b0, X_MAX}) ? X_MAX : s[HPOS_WIDTH-1:0];
  endfunction

  function automatic logic [VPOS_WIDTH-1:0] clamp_y_lo(input logic [VPOS_WIDTH-1:0] p);
    logic signed [VPOS_WIDTH:0] d;
    d = $signed({1'b0, p}) - $signed((VPOS_WIDTH+1)'(BRUSH_SIZE));
    return (d < 0) ? '0 : d[VPOS_WIDTH-1:0];
  endfunction

  function automatic logic [VPOS_WIDTH-1:0] clamp_y_hi(input logic [VPOS_WIDTH-1:0] p);
    logic [VPOS_WIDTH:0] s;
    s = {1'b0, p} + (VPOS_WIDTH+1)'(BRUSH_SIZE);
    return (s > {1'b0, Y_MAX}) ? Y_MAX : s[VPOS_WIDTH-1:0];
  endfunction

  logic [1:0]            state;
  logic [HPOS_WIDTH-1:0] x0, x1, x_cur;
  logic [VPOS_WIDTH-1:0] y0, y1, y_cur;
  logic [VPOS_WIDTH-1:0] row_cnt;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [2:0]            color;
  logic                  accept;
  logic                  row_end;
  logic                  last_row;

  assign accept   = fb_we && fb_ready;
  assign row_end  = (x_cur == x1);
  assign last_row = (y_cur == y1);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  // Control: state sequencing and the write port handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_req || paint_req) state <= S_SETUP;
        end
        S_SETUP: begin
          // row_base reaches y0*RESOLUTION_H after y0 additions; then the first write is presented.
          if (row_cnt == y0) begin
            fb_addr  <= row_base + ADDR_WIDTH'(x0);
            fb_wdata <= color;
            fb_we    <= 1'b1;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (accept) begin
            if (!row_end) begin
              fb_addr <= fb_addr + ADDR_WIDTH'(1);
            end else if (!last_row) begin
              fb_addr <= row_base + ROW_STEP + ADDR_WIDTH'(x0);
            end else begin
              fb_we <= 1'b0;
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operation bounds, colour, row-base accumulation and scan position.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        row_base <= '0;
        row_cnt  <= '0;
        if (clear_req) begin
          x0    <= '0;
          x1    <= X_MAX;
          y0    <= '0;
          y1    <= Y_MAX;
          color <= CLEAR_COLOR;
        end else if (paint_req) begin
          x0    <= clamp_x_lo(cursor_xpos);
          x1    <= clamp_x_hi(cursor_xpos);
          y0    <= clamp_y_lo(cursor_ypos);
          y1    <= clamp_y_hi(cursor_ypos);
          color <= color_in;
        end
      end
      S_SETUP: begin
        if (row_cnt == y0) begin
          x_cur <= x0;
          y_cur <= y0;
        end else begin
          row_base <= row_base + ROW_STEP;
          row_cnt  <= row_cnt + VPOS_WIDTH'(1);
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (!row_end) begin
            x_cur <= x_cur + HPOS_WIDTH'(1);
          end else if (!last_row) begin
            x_cur    <= x0;
            y_cur    <= y_cur + VPOS_WIDTH'(1);
            row_base <= row_base + ROW_STEP;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_brush_fb_writer.sv
// Bench for brush_fb_writer: table of paint operations on a 640x480 instance,
// plus reset-abort and clear/priority sequences (clear on a reduced 64x48 instance).
module tb_brush_fb_writer;
  localparam int H = 640;
  localparam int V = 480;
  localparam int B = 20;
  localparam int SH = 64;
  localparam int SV = 48;
  localparam logic [2:0] S_CLEAR = 3'b011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        paint_req, clear_req, fb_ready;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic [2:0]  col;
  logic        fb_we, busy, done;
  logic [18:0] fb_addr;
  logic [2:0]  fb_wdata;

  logic        s_paint, s_clear, s_ready;
  logic [6:0]  s_cx;
  logic [5:0]  s_cy;
  logic [2:0]  s_col;
  logic        s_we, s_busy, s_done;
  logic [11:0] s_addr;
  logic [2:0]  s_wdata;

  brush_fb_writer dut (
    .clk(clk), .reset(reset), .paint_req(paint_req), .clear_req(clear_req),
    .cursor_xpos(cx), .cursor_ypos(cy), .color_in(col),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  brush_fb_writer #(
    .RESOLUTION_H(SH), .RESOLUTION_V(SV), .HPOS_WIDTH(7), .VPOS_WIDTH(6),
    .ADDR_WIDTH(12), .BRUSH_SIZE(4), .CLEAR_COLOR(S_CLEAR)
  ) dut_small (
    .clk(clk), .reset(reset), .paint_req(s_paint), .clear_req(s_clear),
    .cursor_xpos(s_cx), .cursor_ypos(s_cy), .color_in(s_col),
    .fb_we(s_we), .fb_addr(s_addr), .fb_wdata(s_wdata), .fb_ready(s_ready),
    .busy(s_busy), .done(s_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20) $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [2:0] c;
    bit         toggle;
    int         n;
    int         first;
    int         last;
  } vec_t;

  vec_t vecs[5];

  // Runs one paint on the large instance; abort_after>0 stops observing after that many accepts.
  task automatic run_paint(input int x, input int y, input logic [2:0] c, input bit toggle,
                           input int abort_after, output int n, output int first, output int last);
    int x0, x1, y0, y1, ex, ey, k, last_acc, first_we_k, dones;
    bit prev_we, prev_ready, rdy, fin;
    logic [18:0] prev_addr;
    logic [2:0]  prev_data;
    x0 = (x - B < 0) ? 0 : x - B;
    x1 = (x + B > H - 1) ? H - 1 : x + B;
    y0 = (y - B < 0) ? 0 : y - B;
    y1 = (y + B > V - 1) ? V - 1 : y + B;
    @(negedge clk);
    cx = 10'(x); cy = 9'(y); col = c; paint_req = 1'b1; fb_ready = 1'b0;
    n = 0; first = -1; last = -1; ex = x0; ey = y0; k = 0; dones = 0;
    first_we_k = -1; last_acc = -10; prev_we = 0; prev_ready = 0; fin = 0;
    prev_addr = '0; prev_data = '0;
    while (!fin && k < 8000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        paint_req = 1'b0;
        cx = ~cx; cy = cy ^ 9'h0AA; col = ~c;
        check("busy_after_req", 32'(busy), 32'd1);
      end
      if (abort_after > 0 && n == abort_after) break;
      if (fb_we && first_we_k < 0) begin
        first_we_k = k;
        check("first_write_latency", 32'(k <= y0 + 2), 32'd1);
      end
      if (fb_we && prev_we && !prev_ready) begin
        check("stall_addr", 32'(fb_addr), 32'(prev_addr));
        check("stall_data", 32'(fb_wdata), 32'(prev_data));
      end
      if (done) begin
        dones++;
        check("done_after_last_accept", k, last_acc + 1);
      end else if (dones > 0) begin
        check("busy_low_after_done", 32'(busy), 32'd0);
        fin = 1;
      end
      rdy = toggle ? k[0] : 1'b1;
      fb_ready = rdy;
      if (fb_we && rdy) begin
        check("wr_addr", 32'(fb_addr), 32'(ey * H + ex));
        check("wr_data", 32'(fb_wdata), 32'(c));
        if (first < 0) first = int'(fb_addr);
        last = int'(fb_addr);
        n++;
        last_acc = k;
        if (ex < x1) ex++;
        else begin ex = x0; ey++; end
      end
      prev_we = fb_we; prev_ready = rdy; prev_addr = fb_addr; prev_data = fb_wdata;
    end
    if (abort_after == 0) begin
      check("op_completed", 32'(fin), 32'd1);
      check("done_pulse_count", dones, 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f, l, sn, sdone, k;
    reset = 1'b1; paint_req = 0; clear_req = 0; fb_ready = 0; cx = '0; cy = '0; col = '0;
    s_paint = 0; s_clear = 0; s_ready = 0; s_cx = '0; s_cy = '0; s_col = '0;
    repeat (3) @(negedge clk);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_small_busy", 32'(s_busy), 32'd0);
    reset = 1'b0;

    vecs[0] = '{x: 320, y: 240, c: 3'b101, toggle: 1'b0, n: 1681, first: 141100, last: 166740};
    vecs[1] = '{x: 5,   y: 5,   c: 3'b010, toggle: 1'b0, n: 676,  first: 0,      last: 16025};
    vecs[2] = '{x: 639, y: 479, c: 3'b111, toggle: 1'b0, n: 441,  first: 294379, last: 307199};
    vecs[3] = '{x: 320, y: 240, c: 3'b101, toggle: 1'b1, n: 1681, first: 141100, last: 166740};
    vecs[4] = '{x: 0,   y: 0,   c: 3'b001, toggle: 1'b0, n: 441,  first: 0,      last: 12820};

    for (int i = 0; i < 5; i++) begin
      run_paint(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].toggle, 0, n, f, l);
      check("write_count", n, vecs[i].n);
      check("first_addr", f, vecs[i].first);
      check("last_addr", l, vecs[i].last);
    end

    // Reset in the middle of an operation, then a fresh paint.
    run_paint(320, 240, 3'b110, 1'b0, 100, n, f, l);
    check("accepts_before_reset", n, 100);
    reset = 1'b1;
    @(negedge clk);
    check("abort_fb_we", 32'(fb_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    fb_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("post_abort_no_write", 32'(fb_we), 32'd0);
    end
    run_paint(100, 100, 3'b011, 1'b0, 0, n, f, l);
    check("restart_count", n, 1681);
    check("restart_first", f, 51280);
    check("restart_last", l, 76920);

    // Clear with a simultaneous paint request; paint pulses during busy must be ignored.
    @(negedge clk);
    s_clear = 1'b1; s_paint = 1'b1; s_cx = 7'd10; s_cy = 6'd10; s_col = 3'b110; s_ready = 1'b1;
    sn = 0; sdone = 0; k = 0;
    while (k < 5000) begin
      @(negedge clk);
      k++;
      s_clear = 1'b0;
      s_paint = (k == 50 || k == 1000);
      if (s_paint) check("busy_when_paint_pulsed", 32'(s_busy), 32'd1);
      if (s_done) begin
        sdone++;
      end else if (sdone > 0) begin
        check("clear_busy_low", 32'(s_busy), 32'd0);
        break;
      end
      if (s_we) begin
        check("clear_addr", 32'(s_addr), sn);
        check("clear_data", 32'(s_wdata), 32'(S_CLEAR));
        sn++;
      end
    end
    check("clear_count", sn, SH * SV);
    check("clear_done_pulses", sdone, 1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("ignored_paint_not_queued", 32'(s_busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
